// File: rtl/fsm_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fsm_sequencer_pkg
// Description : Shared state encoding and sizing constants for the pattern
//               sequencer and its table.
// Revision    : 1.0 - initial release
// ============================================================================
package fsm_sequencer_pkg;

  // Sequencer control states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Number of pattern entries and the index width that addresses them
  localparam int TABLE_DEPTH     = 4;
  localparam int IDX_W           = 2;

  // Default width of the per-step dwell count
  localparam int DWELL_W_DEFAULT = 4;

  // Output field widths
  localparam int CODE_W          = 3;
  localparam int SEL_W           = 2;

endpackage : fsm_sequencer_pkg
`default_nettype wire

// File: rtl/fsm_sequencer_seq_table.sv
`default_nettype none
// ============================================================================
// Module      : seq_table
// Description : Four-entry pattern table. Synchronous write, combinational
//               read by index; the reset clears every entry.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_table
  import fsm_sequencer_pkg::*;
#(
  parameter int DWELL_W = DWELL_W_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 we_i,
  input  logic [IDX_W-1:0]     waddr_i,
  input  logic [CODE_W-1:0]    wcode_i,
  input  logic [SEL_W-1:0]     wsel_i,
  input  logic [DWELL_W-1:0]   wdwell_i,
  input  logic [IDX_W-1:0]     raddr_i,
  output logic [CODE_W-1:0]    rcode_o,
  output logic [SEL_W-1:0]     rsel_o,
  output logic [DWELL_W-1:0]   rdwell_o
);

  logic [CODE_W-1:0]  code_q  [TABLE_DEPTH];
  logic [SEL_W-1:0]   sel_q   [TABLE_DEPTH];
  logic [DWELL_W-1:0] dwell_q [TABLE_DEPTH];

  // Entry storage: cleared on reset, one entry written per strobe
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < TABLE_DEPTH; i++) begin
        code_q[i]  <= '0;
        sel_q[i]   <= '0;
        dwell_q[i] <= '0;
      end
    end else if (we_i) begin
      code_q[waddr_i]  <= wcode_i;
      sel_q[waddr_i]   <= wsel_i;
      dwell_q[waddr_i] <= wdwell_i;
    end
  end

  // Read is combinational so the sequencer sees pre-write contents on the
  // edge that performs a write
  assign rcode_o  = code_q[raddr_i];
  assign rsel_o   = sel_q[raddr_i];
  assign rdwell_o = dwell_q[raddr_i];

endmodule : seq_table
`default_nettype wire

// File: rtl/fsm_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : fsm_sequencer
// Description : Plays a 4-step pattern of {code, select} values, holding each
//               step for dwell+1 cycles, with optional looping and abort.
//               All outputs are registered; E/select feed an external Moore
//               output stage.
// Revision    : 1.0 - initial release
// ============================================================================
module fsm_sequencer
  import fsm_sequencer_pkg::*;
#(
  parameter int DWELL_W = DWELL_W_DEFAULT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                stop,
  input  logic                loop,
  input  logic                cfg_we,
  input  logic [IDX_W-1:0]    cfg_addr,
  input  logic [CODE_W-1:0]   cfg_code,
  input  logic [SEL_W-1:0]    cfg_sel,
  input  logic [DWELL_W-1:0]  cfg_dwell,
  output logic [CODE_W-1:0]   E,
  output logic [SEL_W-1:0]    select,
  output logic                busy,
  output logic                done,
  output logic [IDX_W-1:0]    step_idx
);

  state_t             state_q, state_d;
  logic [CODE_W-1:0]  e_q,     e_d;
  logic [SEL_W-1:0]   sel_q,   sel_d;
  logic [IDX_W-1:0]   idx_q,   idx_d;
  logic [DWELL_W-1:0] cnt_q,   cnt_d;
  logic               busy_q,  busy_d;
  logic               done_q,  done_d;

  logic               tbl_we;
  logic [IDX_W-1:0]   tbl_raddr;
  logic [CODE_W-1:0]  tbl_code;
  logic [SEL_W-1:0]   tbl_sel;
  logic [DWELL_W-1:0] tbl_dwell;

  // Configuration is only accepted while idle so a running pattern is stable
  assign tbl_we = cfg_we && (state_q == ST_IDLE);

  // The read port always presents the entry that would be loaded next:
  // entry 0 when starting, otherwise the following step (wraps 3 -> 0 for loop)
  assign tbl_raddr = (state_q == ST_RUN) ? idx_q + IDX_W'(1) : '0;

  seq_table #(
    .DWELL_W (DWELL_W)
  ) u_seq_table (
    .clk      (clk),
    .reset    (reset),
    .we_i     (tbl_we),
    .waddr_i  (cfg_addr),
    .wcode_i  (cfg_code),
    .wsel_i   (cfg_sel),
    .wdwell_i (cfg_dwell),
    .raddr_i  (tbl_raddr),
    .rcode_o  (tbl_code),
    .rsel_o   (tbl_sel),
    .rdwell_o (tbl_dwell)
  );

  // Next-state, step loading and dwell countdown
  always_comb begin
    state_d = state_q;
    e_d     = e_q;
    sel_d   = sel_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start && !stop) begin
          state_d = ST_RUN;
          e_d     = tbl_code;
          sel_d   = tbl_sel;
          idx_d   = '0;
          cnt_d   = tbl_dwell;
        end
      end

      ST_RUN: begin
        if (stop) begin
          state_d = ST_IDLE;
          e_d     = '0;
          sel_d   = '0;
          idx_d   = '0;
          cnt_d   = '0;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - DWELL_W'(1);
        end else if ((idx_q != IDX_W'(TABLE_DEPTH - 1)) || loop) begin
          e_d   = tbl_code;
          sel_d = tbl_sel;
          idx_d = tbl_raddr;
          cnt_d = tbl_dwell;
        end else begin
          state_d = ST_DONE;
          e_d     = '0;
          sel_d   = '0;
          idx_d   = '0;
          cnt_d   = '0;
          done_d  = 1'b1;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
        e_d     = '0;
        sel_d   = '0;
        idx_d   = '0;
        cnt_d   = '0;
      end
    endcase

    busy_d = (state_d == ST_RUN);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      e_q     <= '0;
      sel_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      e_q     <= e_d;
      sel_q   <= sel_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign E        = e_q;
  assign select   = sel_q;
  assign step_idx = idx_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule : fsm_sequencer
`default_nettype wire

// File: tb/tb_fsm_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_fsm_sequencer
// Description : Directed self-checking bench for fsm_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fsm_sequencer;

  logic       clk = 1'b0;
  logic       reset, start, stop, loop, cfg_we;
  logic [1:0] cfg_addr;
  logic [2:0] cfg_code;
  logic [1:0] cfg_sel;
  logic [3:0] cfg_dwell;
  logic [2:0] E;
  logic [1:0] select;
  logic       busy, done;
  logic [1:0] step_idx;

  int n_total = 0;
  int n_bad   = 0;

  fsm_sequencer #(.DWELL_W(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .stop     (stop),
    .loop     (loop),
    .cfg_we   (cfg_we),
    .cfg_addr (cfg_addr),
    .cfg_code (cfg_code),
    .cfg_sel  (cfg_sel),
    .cfg_dwell(cfg_dwell),
    .E        (E),
    .select   (select),
    .busy     (busy),
    .done     (done),
    .step_idx (step_idx)
  );

  always #5 clk = ~clk;

  // Single comparison point
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; sample point is 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [2:0] c, input logic [1:0] s, input logic [3:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_code = c; cfg_sel = s; cfg_dwell = d;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic chk_out(input string tag, input logic [2:0] e, input logic [1:0] s,
                         input logic [1:0] idx, input logic b, input logic d);
    chk({tag, ".E"},    32'(E),        32'(e));
    chk({tag, ".sel"},  32'(select),   32'(s));
    chk({tag, ".idx"},  32'(step_idx), 32'(idx));
    chk({tag, ".busy"}, 32'(busy),     32'(b));
    chk({tag, ".done"}, 32'(done),     32'(d));
  endtask

  // Expected pattern for the reference table, one element per cycle
  logic [2:0] exp_e   [7] = '{3'b001, 3'b010, 3'b010, 3'b101, 3'b011, 3'b011, 3'b011};
  logic [1:0] exp_sel [7] = '{2'b00,  2'b00,  2'b00,  2'b11,  2'b00,  2'b00,  2'b00};
  logic [1:0] exp_idx [7] = '{2'd0,   2'd1,   2'd1,   2'd2,   2'd3,   2'd3,   2'd3};

  initial begin
    reset = 1'b1; start = 1'b0; stop = 1'b0; loop = 1'b0; cfg_we = 1'b0;
    cfg_addr = '0; cfg_code = '0; cfg_sel = '0; cfg_dwell = '0;
    tick(); tick();
    reset = 1'b0;
    chk_out("reset", 3'b000, 2'b00, 2'd0, 1'b0, 1'b0);

    wr(2'd0, 3'b001, 2'b00, 4'd0);
    wr(2'd1, 3'b010, 2'b00, 4'd1);
    wr(2'd2, 3'b101, 2'b11, 4'd0);
    wr(2'd3, 3'b011, 2'b00, 4'd2);

    // Single pass, loop=0
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      if (i != 0) tick();
      chk_out($sformatf("pass%0d", i), exp_e[i], exp_sel[i], exp_idx[i], 1'b1, 1'b0);
    end
    tick();
    chk_out("done_pulse", 3'b000, 2'b00, 2'd0, 1'b0, 1'b1);
    tick();
    chk_out("back_idle", 3'b000, 2'b00, 2'd0, 1'b0, 1'b0);

    // Looping pass
    loop = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 1; i < 7; i++) begin
      tick();
      chk($sformatf("loop%0d.E", i), 32'(E), 32'(exp_e[i]));
      chk($sformatf("loop%0d.done", i), 32'(done), 32'd0);
    end
    tick();
    chk_out("loop_wrap", 3'b001, 2'b00, 2'd0, 1'b1, 1'b0);
    stop = 1'b1; tick(); stop = 1'b0; loop = 1'b0;
    chk_out("loop_stop", 3'b000, 2'b00, 2'd0, 1'b0, 1'b0);

    // Stop during second cycle of entry 1
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick();
    chk_out("e1_cyc2", 3'b010, 2'b00, 2'd1, 1'b1, 1'b0);
    stop = 1'b1; tick(); stop = 1'b0;
    chk_out("abort", 3'b000, 2'b00, 2'd0, 1'b0, 1'b0);
    tick();
    chk("abort_nodone", 32'(done), 32'd0);
    start = 1'b1; tick(); start = 1'b0;
    chk_out("replay", 3'b001, 2'b00, 2'd0, 1'b1, 1'b0);

    // Write while busy must be ignored; start while busy ignored too
    start = 1'b1;
    wr(2'd0, 3'b111, 2'b01, 4'd5);
    start = 1'b0;
    chk("busy_wr_step", 32'(E), 32'(3'b010));
    stop = 1'b1; tick(); stop = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    chk_out("busy_wr_ign", 3'b001, 2'b00, 2'd0, 1'b1, 1'b0);

    // Reset mid-run at step 2
    tick(); tick(); tick();
    chk_out("at_step2", 3'b101, 2'b11, 2'd2, 1'b1, 1'b0);
    reset = 1'b1; start = 1'b1; stop = 1'b1; tick(); reset = 1'b0; start = 1'b0; stop = 1'b0;
    chk_out("mid_reset", 3'b000, 2'b00, 2'd0, 1'b0, 1'b0);
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i != 0) tick();
      chk_out($sformatf("cleared%0d", i), 3'b000, 2'b00, 2'(i), 1'b1, 1'b0);
    end
    tick();
    chk_out("cleared_done", 3'b000, 2'b00, 2'd0, 1'b0, 1'b1);
    tick();

    // start and stop together in IDLE
    start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
    chk_out("start_stop", 3'b000, 2'b00, 2'd0, 1'b0, 1'b0);

    // Maximum dwell: held exactly 16 cycles
    wr(2'd0, 3'b110, 2'b10, 4'd15);
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (i != 0) tick();
      chk($sformatf("dw15_%0d.E", i), 32'(E), 32'(3'b110));
      chk($sformatf("dw15_%0d.idx", i), 32'(step_idx), 32'd0);
    end
    tick();
    chk_out("dw15_next", 3'b000, 2'b00, 2'd1, 1'b1, 1'b0);
    stop = 1'b1; tick(); stop = 1'b0;

    // Write and start in the same cycle: old contents play
    start = 1'b1;
    wr(2'd0, 3'b101, 2'b01, 4'd0);
    start = 1'b0;
    chk_out("wr_start_old", 3'b110, 2'b10, 2'd0, 1'b1, 1'b0);
    stop = 1'b1; tick(); stop = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    chk_out("wr_start_new", 3'b101, 2'b01, 2'd0, 1'b1, 1'b0);
    stop = 1'b1; tick(); stop = 1'b0;

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule : tb_fsm_sequencer
`default_nettype wire
